// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the sw_rr packet switch.
// Holds frame-type codes, the input and arbiter state enums, and the
// ASSERT/NEGATE logic levels.
package sw_pkg;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  // Frame type field, top two bits of every frame
  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } in_st_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } arb_st_t;

endpackage

// File: rtl/sw_fifo.sv
// sw_fifo: synchronous frame FIFO with free-slot count.
// Ports: clk, rst (async, active-high), wr/wdata push, rd pop,
//        rdata_c (current front frame), empty_c, free_c (free slots).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sw_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [W-1:0]               wdata,
  input  logic                       rd,
  output logic [W-1:0]               rdata_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     free_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty_c = (wptr == rptr);
  assign free_c  = (AW+1)'(DEPTH) - (wptr - rptr);
  assign rdata_c = mem[rptr[AW-1:0]];

  // Pointer update; writes to a full FIFO and pops of an empty one are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr && !full)    wptr <= wptr + (AW+1)'(1);
      if (rd && !empty_c) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sw_rr.sv
// sw_rr: N-port buffered packet switch with per-output round-robin arbiters.
// Ports: clk, rst (async, active-high),
//        i        packed input frames, one per port,
//        o        packed registered output frames, one per port,
//        drop_cnt packed saturating per-input dropped-packet counters.
// Each input admits a whole packet only if its FIFO can hold MAXLEN frames;
// otherwise the packet is discarded and counted.
module sw_rr
  import sw_pkg::*;
#(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DATAW  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned MAXLEN = 4,
  parameter int unsigned CNTW   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS*(DATAW+2)-1:0]    i,
  output logic [NPORTS*(DATAW+2)-1:0]    o,
  output logic [NPORTS*CNTW-1:0]         drop_cnt
);

  localparam int unsigned FRMW  = DATAW + 2;
  localparam int unsigned PORTW = $clog2(NPORTS);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [AW:0] MAXF  = (AW+1)'(MAXLEN);

  logic [FRMW-1:0]               fin   [NPORTS];
  logic [FRMW-1:0]               front [NPORTS];
  logic [AW:0]                   free  [NPORTS];
  logic [NPORTS-1:0]             empty;
  logic [NPORTS-1:0]             rd;
  logic [NPORTS-1:0][NPORTS-1:0] pop_m;

  // Input side: admission FSM, FIFO and drop counter per input
  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    in_st_t            st_q, st_d;
    logic              drop_q, drop_d;
    logic              inc_c, wr_c;
    logic [CNTW-1:0]   cnt_q;
    logic [1:0]        ft;
    logic [NPORTS-1:0] pop_col;

    assign fin[p] = i[p*FRMW +: FRMW];
    assign ft     = fin[p][FRMW-1:DATAW];

    // Gather pop requests from every arbiter for this FIFO
    for (genvar d = 0; d < NPORTS; d++) begin : g_col
      assign pop_col[d] = pop_m[d][p];
    end
    assign rd[p] = |pop_col;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= IDLE;
        drop_q <= NEGATE;
        cnt_q  <= '0;
      end else begin
        st_q   <= st_d;
        drop_q <= drop_d;
        if (inc_c && (cnt_q != '1)) cnt_q <= cnt_q + CNTW'(1);
      end
    end

    // Admission decision uses pre-edge free count
    always_comb begin
      st_d   = st_q;
      drop_d = drop_q;
      inc_c  = NEGATE;
      case (st_q)
        IDLE: begin
          if (ft == FT_HEAD) begin
            st_d   = IN_PKT;
            drop_d = (free[p] < MAXF);
            inc_c  = drop_d;
          end
        end
        IN_PKT: begin
          if (ft == FT_TAIL) begin
            st_d   = IDLE;
            drop_d = NEGATE;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    // Idle frames and orphan body/tail frames are never written
    always_comb begin
      wr_c = NEGATE;
      case (st_q)
        IDLE:    wr_c = (ft == FT_HEAD) && (free[p] >= MAXF);
        IN_PKT:  wr_c = !drop_q && ((ft == FT_BODY) || (ft == FT_TAIL));
        default: wr_c = NEGATE;
      endcase
    end

    sw_fifo #(
      .W     (FRMW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_c),
      .wdata   (fin[p]),
      .rd      (rd[p]),
      .rdata_c (front[p]),
      .empty_c (empty[p]),
      .free_c  (free[p])
    );

    assign drop_cnt[p*CNTW +: CNTW] = cnt_q;
  end

  // Output side: packet-granular round-robin arbiter per output
  for (genvar d = 0; d < NPORTS; d++) begin : g_arb
    arb_st_t           st_q, st_d;
    logic [PORTW-1:0]  gnt_q, gnt_d, ptr_q, ptr_d;
    logic [FRMW-1:0]   o_q, o_d;
    logic [NPORTS-1:0] req_c, pop_c;
    logic              hit_c;
    int                idx_c;
    logic [PORTW-1:0]  idxw_c;

    // An input requests this output when its FIFO front is a head for d
    for (genvar k = 0; k < NPORTS; k++) begin : g_req
      assign req_c[k] = !empty[k] && (front[k][FRMW-1:DATAW] == FT_HEAD) &&
                        (front[k][PORTW-1:0] == PORTW'(d));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= FREE;
        gnt_q <= '0;
        ptr_q <= '0;
        o_q   <= '0;
      end else begin
        st_q  <= st_d;
        gnt_q <= gnt_d;
        ptr_q <= ptr_d;
        o_q   <= o_d;
      end
    end

    // Grant first requester at or after ptr; release after the tail pops
    always_comb begin
      st_d   = st_q;
      gnt_d  = gnt_q;
      ptr_d  = ptr_q;
      hit_c  = NEGATE;
      idx_c  = 0;
      idxw_c = '0;
      case (st_q)
        FREE: begin
          for (int k = 0; k < int'(NPORTS); k++) begin
            idx_c  = (int'(ptr_q) + k) % int'(NPORTS);
            idxw_c = PORTW'(idx_c);
            if (!hit_c && req_c[idxw_c]) begin
              hit_c = ASSERT;
              gnt_d = idxw_c;
              st_d  = BUSY;
            end
          end
        end
        BUSY: begin
          if (!empty[gnt_q] && (front[gnt_q][FRMW-1:DATAW] == FT_TAIL)) begin
            st_d  = FREE;
            ptr_d = (int'(gnt_q) == int'(NPORTS) - 1) ? '0 : gnt_q + PORTW'(1);
          end
        end
        default: st_d = FREE;
      endcase
    end

    // Stream the granted FIFO; an empty FIFO mid-packet yields idle
    always_comb begin
      o_d   = {FT_IDLE, DATAW'(0)};
      pop_c = '0;
      if ((st_q == BUSY) && !empty[gnt_q]) begin
        o_d          = front[gnt_q];
        pop_c[gnt_q] = ASSERT;
      end
    end

    assign pop_m[d]             = pop_c;
    assign o[d*FRMW +: FRMW]    = o_q;
  end

endmodule

// File: doc/sw_rr.md
# sw_rr

Parametrised N-port packet switch, the buffered successor to the 4-way `sw`. It uses the same head/body/tail frame format. Each input has a frame FIFO, and each output has a packet-granular round-robin arbiter, so contending packets are queued and delivered rather than lost. Packets that cannot be buffered are dropped whole and counted per input.

## Interface
- `NPORTS`, 4, number of input and output ports (≥2).
- `DATAW`, 8, frame payload width. Frame width `FRMW` = `DATAW`+2.
- `DEPTH`, 8, per-input FIFO depth in frames (power of two, ≥`MAXLEN`).
- `MAXLEN`, 4, maximum legal packet length in frames, head and tail included.
- `CNTW`, 8, drop counter width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i`  in  `NPORTS`×`FRMW`  packed input frames, one per port per cycle.
- `o`  out  `NPORTS`×`FRMW`  packed output frames, registered.
- `drop_cnt`  out  `NPORTS`×`CNTW`  packed per-input dropped-packet counters, saturating.

## Operation
- Frame type is bits [`FRMW`-1:`DATAW`]:
  - 2'b00 = idle.
  - 2'b10 = head.
  - 2'b01 = body.
  - 2'b11 = tail.
  - Data is [`DATAW`-1:0].
- Head destination is data[`PORTW`-1:0], with `PORTW` = clog2(`NPORTS`). All other head data bits are passed through untouched.
- A packet is head, then zero or more bodies, then tail, with length ≤`MAXLEN`. Longer packets are illegal stimulus.
- Input side: each input runs a 2-state FSM.
  - States are `IDLE` and `IN_PKT`. The sub-state `DROP` applies to `IN_PKT`.
  - In `IDLE`, a head is admitted when FIFO free slots ≥`MAXLEN`. The FSM then moves to `IN_PKT` and writes frames.
  - If the head arrives while free slots <`MAXLEN`, the FSM moves to `IN_PKT`/`DROP`. All frames through the tail are discarded, and `drop_cnt` increments once.
  - A tail returns the FSM to `IDLE`.
  - A body or tail that arrives in `IDLE` is an orphan. It is discarded silently and not counted.
  - Idle frames are never written. An idle frame inside a packet is ignored; the packet stays open.
  - A head that arrives in `IN_PKT` closes nothing. It is illegal stimulus.
- Output side: one arbiter per output, with states `FREE` and `BUSY`.
  - An input requests output d when its FIFO head frame is a head with destination d.
  - In `FREE`, the arbiter grants the requesting input first at or after pointer `ptr[d]`, then moves to `BUSY`.
  - In `BUSY`, the granted FIFO is popped one frame per cycle into `o[d]`. When the tail pops, the arbiter returns to `FREE` and `ptr[d]` becomes granted index+1 (mod `NPORTS`).
  - If the granted FIFO is momentarily empty mid-packet, `o[d]` outputs idle and the grant is held.
  - An input is granted to at most one output. Its FIFO head has only one destination, so no conflict arises.
  - Self-forwarding (input k to output k) is legal.
- Frames are forwarded unmodified.
- `drop_cnt` saturates at all-ones.

## Timing
- Reset state:
  - All `o` = 0 (idle).
  - All `drop_cnt` = 0.
  - FIFOs empty.
  - Input FSMs in `IDLE`.
  - Arbiters in `FREE`.
  - All `ptr` = 0.
- `rst` clears asynchronously, mid-packet included. `o` goes idle immediately and partial packets are lost.
- After reset release, frames of a packet already in flight are treated as orphans.
- Uncontended latency: a head sampled at edge k is granted at edge k+1 and appears on `o` after edge k+2. Later frames of a back-to-back packet follow one per cycle.
- Between consecutive packets on the same output, there is exactly one idle cycle (re-arbitration).
- Simultaneous write and pop on a FIFO is allowed. An admission check and a pop in the same cycle use the pre-edge occupancy.
- FIFO pointers are clog2(`DEPTH`)+1 bits. Full is flagged when the MSBs differ and the rest are equal. Pointers wrap freely.

## Structure
- Shared package `sw_pkg` holds:
  - Frame type constants `FT_IDLE`, `FT_HEAD`, `FT_BODY`, `FT_TAIL`.
  - Input FSM enum and arbiter enum typedefs.
  - The `ASSERT`/`NEGATE` levels.
- Sub-module `sw_fifo` implements one synchronous FIFO (`FRMW` × `DEPTH`, with free count output), instantiated `NPORTS` times.
- Input FSMs and arbiters live in `sw_rr` inside generate loops.

## Test plan
- Single packet: after reset, i0 drives head 10'b10_0000_0000, bodies 0x00 and 0x01, then tail 0x02. Expect the same four frames on o0 on consecutive cycles, starting 2 cycles after the head. Other outputs stay idle and `drop_cnt` stays 0.
- Contention: i0–i3 each send a 4-frame packet to port 1 in the same cycle. Expect o1 to deliver the packets from inputs 0, 1, 2, 3 in that order, each packet intact with one idle gap. All `drop_cnt` stay 0.
- Fairness: repeat the contention test immediately with `ptr[1]`=0 after wrap. Then, after a single i1 packet to port 1, repeat again. Expect the order 2, 3, 0, 1.
- Permutation: i0 to port 1, i1 to port 2, i2 to port 3, i3 to port 0 simultaneously. Expect all four outputs to stream in parallel at 2-cycle latency.
- Overflow: `DEPTH`=8, `MAXLEN`=4. i0 holds o0 with 4 back-to-back packets while i1 sends 4 back-to-back packets to port 0. Expect `drop_cnt[1]` to match the scoreboard prediction. o0 never carries a partial packet.
- Reset mid-packet: assert `rst` while o2 is in the middle of a packet. Expect `o` idle and counters 0 immediately. The trailing frames are discarded, and the next complete packet is delivered normally.
